scan_display: RTL

SCAN_DISPLAY -- requirements
Module: scan_display

---
 rtl/scan_display.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/scan_display.sv
// ---------------------------------------------------------------------------
// scan_display
//   Time-multiplexed 7-segment scanner. A scan index steps through the digits
//   once per enable tick. The BCD input is copied into a shadow register only
//   when the index wraps, so each frame always shows one consistent value.
//   All outputs are registered. They show the index and shadow value held in
//   the previous cycle.
//
// Parameters
//   NUM_DIGITS       number of multiplexed digits (2..8)
//
// Ports
//   clk              single clock, rising edge
//   reset            synchronous, active-high
//   enable7segmentos one-cycle scan tick from the upstream divider
//   digits_bcd       BCD digits, [3:0] = digit 0 (least significant)
//   colon_on         light the colon decimal points (even, nonzero indices)
//   an_n             active-low one-hot digit select, bit i = digit i
//   seg_n            active-low segments {g,f,e,d,c,b,a}
//   dp_n             active-low decimal point
//   frame_start      one-cycle pulse in the cycle after the index wraps to 0
//
// Build option
//   SCAN_DISPLAY_LEADING_ZERO_BLANK_EN  when defined, the most significant
//   digit is blanked (anodes off, segments off) if its shadow nibble is 0.
// ---------------------------------------------------------------------------
module scan_display #(
    parameter int unsigned NUM_DIGITS = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable7segmentos,
    input  logic [4*NUM_DIGITS-1:0] digits_bcd,
    input  logic                    colon_on,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic                    frame_start
);

    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

    // ST_BLANK: no tick seen since reset, so every digit stays dark.
    typedef enum logic {
        ST_BLANK,
        ST_SCAN
    } state_t;

    state_t                  state, state_nx;
    logic [IW-1:0]           idx, idx_nx;
    logic [4*NUM_DIGITS-1:0] shadow, shadow_nx;
    logic                    wrap;
    logic [3:0]              nib;
    logic                    blank_msd;
    logic [NUM_DIGITS-1:0]   an_nx;
    logic [6:0]              seg_nx;
    logic                    dp_nx;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;   // non-BCD shows a dash
        endcase
        return s;
    endfunction

    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        shadow_nx = shadow;
        wrap      = enable7segmentos && (idx == LAST);

        if (enable7segmentos) begin
            state_nx = ST_SCAN;
            idx_nx   = wrap ? '0 : idx + 1'b1;
            if (wrap) begin
                shadow_nx = digits_bcd;
            end
        end

        // Constant-index mux keeps the nibble select free of width games.
        nib = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib = shadow[4*i +: 4];
            end
        end

`ifdef SCAN_DISPLAY_LEADING_ZERO_BLANK_EN
        blank_msd = (idx == LAST) && (nib == 4'd0);
`else
        blank_msd = 1'b0;
`endif

        an_nx  = '1;
        seg_nx = '1;
        dp_nx  = 1'b1;
        if (state == ST_SCAN) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                an_nx[i] = (idx != IW'(i));
            end
            seg_nx = seg_decode(nib);
            dp_nx  = !(colon_on && !idx[0] && (idx != '0));
            if (blank_msd) begin
                an_nx  = '1;
                seg_nx = '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_BLANK;
            idx         <= '0;
            shadow      <= '0;
            an_n        <= '1;
            seg_n       <= '1;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            shadow      <= shadow_nx;
            an_n        <= an_nx;
            seg_n       <= seg_nx;
            dp_n        <= dp_nx;
            frame_start <= wrap;
        end
    end

endmodule
